// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: CPU-side write and status bundle for uart_tx_fifo.
// master drives write_i/val_i; slave returns full/empty/level/overflow/busy.
interface uart_tx_fifo_if #(
   parameter int DEPTH     = 16,
   parameter int DATA_BITS = 8
);
   localparam int LW = $clog2(DEPTH + 1);

   logic                 write_i;
   logic [DATA_BITS-1:0] val_i;
   logic                 full_o;
   logic                 empty_o;
   logic [LW-1:0]        level_o;
   logic                 overflow_o;
   logic                 busy_o;

   modport master (
      output write_i, val_i,
      input  full_o, empty_o, level_o, overflow_o, busy_o
   );

   modport slave (
      input  write_i, val_i,
      output full_o, empty_o, level_o, overflow_o, busy_o
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, start/data(LSB first)/stop.
// Ports: clk_i, rst_i (sync, high), bus (write/status bundle), uart_tx_o.
module uart_tx_fifo #(
   parameter int FREQ      = 27000000,
   parameter int BAUD      = 115200,
   parameter int DEPTH     = 16,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   uart_tx_fifo_if.slave bus,
   output logic          uart_tx_o
);
   localparam int DIV = FREQ / BAUD;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW  = $clog2(DEPTH + 1);

   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [3:0]    DB_LAST  = 4'(DATA_BITS - 1);
   localparam logic [3:0]    SB_LAST  = 4'(STOP_BITS - 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [LW-1:0]        level;
   logic                 ovf_q;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [3:0]           bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 tx_q;
   logic                 busy_q;

   logic full;
   logic empty;
   logic cnt_end;
   logic pop;
   logic push;

   assign full    = (level == LVL_FULL);
   assign empty   = (level == '0);
   assign cnt_end = (cnt == CNT_LAST);

   // Pop when idle, or on the very last cycle of the last stop bit so
   // the next frame starts with no idle gap.
   always_comb begin
      pop = 1'b0;
      unique case (state)
         IDLE:  pop = !empty;
         START: pop = 1'b0;
         DATA:  pop = 1'b0;
         STOP:  pop = cnt_end && (bit_idx == SB_LAST) && !empty;
      endcase
   end

   // A pop in the same cycle frees a slot, so a write to a full FIFO
   // is still accepted then.
   assign push = bus.write_i && (!full || pop);

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= bus.val_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         ovf_q <= bus.write_i && full && !pop;
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            level <= level + LW'(1);
         end else if (pop && !push) begin
            level <= level - LW'(1);
         end
      end
   end

   // The line register follows the state one cycle later; the shift at
   // a bit boundary therefore never touches the bit on the wire.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               tx_q    <= 1'b1;
               cnt     <= '0;
               bit_idx <= '0;
               if (!empty) begin
                  shreg  <= mem[rd_ptr];
                  state  <= START;
                  busy_q <= 1'b1;
               end
            end
            START: begin
               tx_q <= 1'b0;
               if (cnt_end) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= DATA;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               tx_q <= shreg[0];
               if (cnt_end) begin
                  cnt   <= '0;
                  shreg <= shreg >> 1;
                  if (bit_idx == DB_LAST) begin
                     bit_idx <= '0;
                     state   <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            STOP: begin
               tx_q <= 1'b1;
               if (cnt_end) begin
                  cnt <= '0;
                  if (bit_idx == SB_LAST) begin
                     bit_idx <= '0;
                     if (!empty) begin
                        shreg <= mem[rd_ptr];
                        state <= START;
                     end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                     end
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
         endcase
      end
   end

   assign uart_tx_o      = tx_q;
   assign bus.busy_o     = busy_q;
   assign bus.full_o     = full;
   assign bus.empty_o    = empty;
   assign bus.level_o    = level;
   assign bus.overflow_o = ovf_q;
endmodule
